// File: rtl/fcpu_pkg.sv
// Shared widths for the fcpu core and its memory-side request path.
package fcpu_pkg;
    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int INSTR_W  = 8;
endpackage

// File: rtl/mmu_request_arbiter.sv
// Round-robin arbiter muxing N_REQ requesters onto one MMU port; grant registered, m_valid one cycle after request.
// Backpressure: the grant is held while m_ready is low and released on handshake or when the requester withdraws.
module mmu_request_arbiter
    import fcpu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*RSV_ID_W-1:0] req_rsv_id,
    input  logic [N_REQ*INSTR_W-1:0]  req_opcode,
    input  logic [N_REQ*DATA_W-1:0]   req_address,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      m_valid,
    output logic [RSV_ID_W-1:0]       m_rsv_id,
    output logic [INSTR_W-1:0]        m_opcode,
    output logic [DATA_W-1:0]         m_address,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_ready,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx
);

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;

    // (base + off) mod N_REQ; both operands are below N_REQ so one subtract suffices.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_add(rr_ptr_q, i)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_add(rr_ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        case (state_q)
            ARB: begin
                if (pick_vld) begin
                    state_d     = GRANT;
                    grant_idx_d = pick_idx;
                end
            end
            GRANT: begin
                // Either a handshake or a withdrawal ends the grant.
                if (!req_valid[grant_idx_q] || m_ready) begin
                    state_d  = ARB;
                    rr_ptr_d = wrap_add(grant_idx_q, 1);
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    always_comb begin
        req_ready   = '0;
        m_valid     = 1'b0;
        m_rsv_id    = '0;
        m_opcode    = '0;
        m_address   = '0;
        m_data      = '0;
        grant_valid = (state_q == GRANT);
        if (state_q == GRANT) begin
            m_valid = req_valid[grant_idx_q];
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_idx_q == IDX_W'(i)) begin
                    m_rsv_id     = req_rsv_id[i*RSV_ID_W +: RSV_ID_W];
                    m_opcode     = req_opcode[i*INSTR_W +: INSTR_W];
                    m_address    = req_address[i*DATA_W +: DATA_W];
                    m_data       = req_data[i*DATA_W +: DATA_W];
                    req_ready[i] = m_ready;
                end
            end
        end
    end

    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_mmu_request_arbiter.sv
// Table-driven and scoreboarded bench for the round-robin MMU request arbiter.
module tb_mmu_request_arbiter;
    import fcpu_pkg::*;

    localparam int N   = 4;
    localparam int PW  = RSV_ID_W + INSTR_W + 2 * DATA_W;

    logic                  clk = 1'b0;
    logic                  nrst;
    logic [N-1:0]          req_valid;
    logic [N*RSV_ID_W-1:0] req_rsv_id;
    logic [N*INSTR_W-1:0]  req_opcode;
    logic [N*DATA_W-1:0]   req_address;
    logic [N*DATA_W-1:0]   req_data;
    logic [N-1:0]          req_ready;
    logic                  m_valid;
    logic [RSV_ID_W-1:0]   m_rsv_id;
    logic [INSTR_W-1:0]    m_opcode;
    logic [DATA_W-1:0]     m_address;
    logic [DATA_W-1:0]     m_data;
    logic                  m_ready;
    logic                  grant_valid;
    logic [1:0]            grant_idx;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb[$];

    mmu_request_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_rsv_id(req_rsv_id), .req_opcode(req_opcode),
        .req_address(req_address), .req_data(req_data), .req_ready(req_ready),
        .m_valid(m_valid), .m_rsv_id(m_rsv_id), .m_opcode(m_opcode),
        .m_address(m_address), .m_data(m_data), .m_ready(m_ready),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       nrst;
        logic [3:0] rv;
        logic       mr;
        logic       mv;
        logic       gv;
        logic [1:0] gi;
        logic [3:0] rdy;
    } vec_t;

    function automatic vec_t V(input logic n, input logic [3:0] rv, input logic mr,
                               input logic mv, input logic gv, input logic [1:0] gi,
                               input logic [3:0] rdy);
        vec_t v;
        v.nrst = n; v.rv = rv; v.mr = mr; v.mv = mv; v.gv = gv; v.gi = gi; v.rdy = rdy;
        return v;
    endfunction

    function automatic logic [PW-1:0] exp_pay(input logic gv, input logic [1:0] gi);
        logic [RSV_ID_W-1:0] r;
        logic [INSTR_W-1:0]  o;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   d;
        if (!gv) return '0;
        r = RSV_ID_W'(5 + int'(gi));
        o = INSTR_W'(48 + int'(gi));
        a = DATA_W'(32'h1000_0000 + 32'(gi) * 32'd16);
        d = DATA_W'(32'hCAFE_0000 + 32'(gi));
        return {r, o, a, d};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every handshake must match the next queued grant index and its payload.
    always @(negedge clk) begin
        if (nrst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hs_unexpected: got idx %0d expected no handshake", grant_idx);
            end else begin
                logic [1:0] e;
                e = sb.pop_front();
                chk("hs_idx", 128'(grant_idx), 128'(e));
                chk("hs_ready", 128'(req_ready), 128'(4'b0001 << e));
                chk("hs_payload", 128'({m_rsv_id, m_opcode, m_address, m_data}), 128'(exp_pay(1'b1, e)));
            end
        end
    end

    vec_t tbl[$];

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            req_rsv_id[i*RSV_ID_W +: RSV_ID_W] = RSV_ID_W'(5 + i);
            req_opcode[i*INSTR_W +: INSTR_W]   = INSTR_W'(48 + i);
            req_address[i*DATA_W +: DATA_W]    = DATA_W'(32'h1000_0000 + 32'(i) * 32'd16);
            req_data[i*DATA_W +: DATA_W]       = DATA_W'(32'hCAFE_0000 + 32'(i));
        end
        nrst = 1'b0; req_valid = '0; m_ready = 1'b0;

        // single request with 3 stall cycles, then handshake
        tbl.push_back(V(1, 4'b0000, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0001, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0001, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0001, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0001, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0001, 1, 1, 1, 0, 4'b0001));
        tbl.push_back(V(1, 4'b0000, 0, 0, 0, 0, 4'b0000));
        // pointer now 1: requester 1 beats 0
        tbl.push_back(V(1, 4'b0011, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0011, 1, 1, 1, 1, 4'b0010));
        // reset, then all valid: 0,1,2,3,0
        tbl.push_back(V(0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(V(1, 4'b1111, 1, 0, 0, 0, 4'b0000));
            tbl.push_back(V(1, 4'b1111, 1, 1, 1, 2'(k), 4'b0001 << (k % 4)));
        end
        // withdrawal of requester 2
        tbl.push_back(V(1, 4'b0100, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0100, 0, 1, 1, 2, 4'b0000));
        tbl.push_back(V(1, 4'b0000, 0, 0, 1, 2, 4'b0000));
        // wrap: pointer 3 with 1001
        tbl.push_back(V(1, 4'b1001, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b1001, 1, 1, 1, 3, 4'b1000));
        tbl.push_back(V(1, 4'b1001, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b1001, 1, 1, 1, 0, 4'b0001));
        // reset mid-grant
        tbl.push_back(V(1, 4'b0100, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0100, 0, 1, 1, 2, 4'b0000));
        tbl.push_back(V(0, 4'b0100, 0, 1, 1, 2, 4'b0000));
        tbl.push_back(V(1, 4'b0100, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b0100, 1, 1, 1, 2, 4'b0100));
        // reset clears a pointer of 3: 1010 must pick 1 then 3
        tbl.push_back(V(0, 4'b0000, 0, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b1010, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b1010, 1, 1, 1, 1, 4'b0010));
        tbl.push_back(V(1, 4'b1010, 1, 0, 0, 0, 4'b0000));
        tbl.push_back(V(1, 4'b1010, 1, 1, 1, 3, 4'b1000));
        tbl.push_back(V(1, 4'b0000, 1, 0, 0, 0, 4'b0000));

        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < tbl.size(); r++) begin
            nrst = tbl[r].nrst; req_valid = tbl[r].rv; m_ready = tbl[r].mr;
            if (tbl[r].nrst && tbl[r].mv && tbl[r].mr) sb.push_back(tbl[r].gi);
            @(negedge clk);
            chk($sformatf("row%0d_ctrl", r),
                128'({m_valid, grant_valid, req_ready, (tbl[r].gv ? grant_idx : 2'b00)}),
                128'({tbl[r].mv, tbl[r].gv, tbl[r].rdy, tbl[r].gi}));
            chk($sformatf("row%0d_payload", r),
                128'({m_rsv_id, m_opcode, m_address, m_data}),
                128'(exp_pay(tbl[r].gv, tbl[r].gi)));
            @(posedge clk);
            #1;
        end

        // grant to 1 held through stalls while other requesters toggle
        req_valid = 4'b0010; m_ready = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'($urandom) | 4'b0010;
            @(negedge clk);
            chk($sformatf("stall%0d_ctrl", k),
                128'({m_valid, grant_valid, grant_idx, req_ready}), 128'({1'b1, 1'b1, 2'd1, 4'b0000}));
            chk($sformatf("stall%0d_payload", k),
                128'({m_rsv_id, m_opcode, m_address, m_data}), 128'(exp_pay(1'b1, 2'd1)));
            @(posedge clk); #1;
        end
        req_valid = 4'b1011; m_ready = 1'b1;
        sb.push_back(2'd1);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // fairness: all valid with random stalls, strict rotation from pointer 2
        for (int k = 0; k < 8; k++) sb.push_back(2'((k + 2) % 4));
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            req_valid = 4'b1111;
            m_ready   = 1'($urandom_range(0, 1));
            @(negedge clk);
            @(posedge clk); #1;
            n++;
        end
        req_valid = '0; m_ready = 1'b0;
        chk("fair_pending", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmu_request_arbiter.md
MMU_REQUEST_ARBITER -- requirements
Module: mmu_request_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the single MMU request port; legal range 2..8.
REQ-002 Parameter IDX_W, default $clog2(N_REQ): width of the grant index.
REQ-003 The RSV_ID_W, DATA_W and INSTR_W widths SHALL be taken from fcpu_pkg.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 nrst  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  N_REQ  per-requester request valid.
REQ-007 req_rsv_id  in  N_REQ x RSV_ID_W  per-requester reservation id.
REQ-008 req_opcode  in  N_REQ x INSTR_W  per-requester opcode.
REQ-009 req_address  in  N_REQ x DATA_W  per-requester address.
REQ-010 req_data  in  N_REQ x DATA_W  per-requester store/output data.
REQ-011 req_ready  out  N_REQ  per-requester accept; one-hot or zero.
REQ-012 m_valid  out  1  request valid to the MMU core port.
REQ-013 m_rsv_id / m_opcode / m_address / m_data  out  RSV_ID_W / INSTR_W / DATA_W / DATA_W  payload of the granted requester.
REQ-014 m_ready  in  1  MMU accept.
REQ-015 grant_valid  out  1  a grant is held.
REQ-016 grant_idx  out  IDX_W  index of the held grant.

Function
REQ-017 FSM states: ARB and GRANT; reset state is ARB.
REQ-018 Round-robin pointer rr_ptr (IDX_W bits) SHALL be kept; the highest-priority requester is rr_ptr, then rr_ptr+1, and so on, wrapping modulo N_REQ.
REQ-019 In ARB, if any req_valid is set, the first set bit at or after rr_ptr SHALL be registered into grant_idx and the FSM SHALL move to GRANT on the next edge.
REQ-020 In ARB, with no req_valid set, the FSM SHALL stay in ARB and hold rr_ptr.
REQ-021 In ARB, m_valid, grant_valid and all req_ready bits SHALL be 0; payload outputs SHALL be 0.
REQ-022 In GRANT, the following SHALL hold:
- m_valid = req_valid[grant_idx];
- m_* payload = req_*[grant_idx];
- req_ready[grant_idx] = m_ready, with all other req_ready bits 0;
- grant_valid = 1.
REQ-023 The handshake completes on m_valid && m_ready in GRANT. On that edge the FSM SHALL go to ARB and rr_ptr SHALL become (grant_idx+1) mod N_REQ.
REQ-024 If req_valid[grant_idx] deasserts in GRANT without a handshake, the grant SHALL be released on that edge (go to ARB, rr_ptr = grant_idx+1 mod N_REQ), with no output transfer.
REQ-025 The grant SHALL be held indefinitely while req_valid[grant_idx]=1 and m_ready=0; grant_idx and the payload source SHALL not change.
REQ-026 Requests arriving at other requesters during GRANT SHALL be ignored until the next ARB cycle.
REQ-027 Minimum latency from req_valid rise to m_valid is 1 cycle; minimum spacing between handshakes is 2 cycles.
REQ-028 Fairness: a continuously valid requester SHALL be granted within N_REQ grants.
REQ-029 The wrap case (grant_idx = N_REQ-1) SHALL set rr_ptr to 0.
REQ-030 m_ready while in ARB SHALL have no effect.

Reset
REQ-031 While nrst=0 at a rising edge, the following SHALL be set: state=ARB, rr_ptr=0, grant_idx=0. The outputs grant_valid, m_valid and req_ready SHALL be 0 from the next cycle.
REQ-032 Reset during GRANT SHALL abandon the grant with no handshake; the first arbitration after release SHALL start from requester 0.

Verification
REQ-033 Single request, ready stalls: req_valid=0001, m_ready=0 for 3 cycles then 1 -> m_valid rises 1 cycle after the request; the payload is held stable for 4 cycles; req_ready=0001 only on the handshake cycle; rr_ptr=1 afterwards.
REQ-034 All requesters valid, m_ready=1 -> grants occur in order 0,1,2,3,0 with one handshake every 2 cycles.
REQ-035 Wrap: rr_ptr=3 with req_valid=1001 -> requester 3 is granted first, then rr_ptr=0, then requester 0.
REQ-036 Withdrawal: requester 2 is granted and drops valid before m_ready -> m_valid falls the same cycle; ARB follows; rr_ptr=3; no req_ready pulse.
REQ-037 Reset mid-grant: nrst=0 for 1 cycle during GRANT with req_valid=0100 -> outputs are 0 the next cycle; re-grant to requester 2 occurs after a 1-cycle ARB; rr_ptr was 0 at arbitration.
REQ-038 Payload check: distinct rsv_id, opcode, address and data per requester -> m_* match the granted index on every handshake cycle.
